// File: rtl/instr_done_collector_pkg.sv
// Shared definitions for the instruction-done collector: completion source
// encodings and default widths.
package instr_done_collector_pkg;

    localparam int unsigned DONE_SRC_W     = 2;
    localparam int unsigned NUM_SRC        = 4;
    localparam int unsigned DEF_INFO_W     = 32;
    localparam int unsigned DEF_WFID_W     = 6;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [DONE_SRC_W-1:0] {
        DONE_SRC_VGPR_ALU = 2'd0,
        DONE_SRC_VGPR_LSU = 2'd1,
        DONE_SRC_SGPR_ALU = 2'd2,
        DONE_SRC_SGPR_LSU = 2'd3
    } done_src_e;

endpackage

// File: rtl/instr_done_collector_done_fifo.sv
// Per-source wfid FIFO. A push on a full FIFO is accepted only when the same
// cycle also pops, so occupancy never exceeds FIFO_DEPTH.
module done_fifo
    import instr_done_collector_pkg::*;
#(
    parameter int unsigned WFID_W     = DEF_WFID_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WFID_W-1:0] din,
    output logic [WFID_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WFID_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_done_collector.sv
// Collects done events from four completion sources, round-robin serializes
// them onto one table read port and emits registered retire records.
module instr_done_collector
    import instr_done_collector_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned INFO_W     = DEF_INFO_W,
    parameter int unsigned WFID_W     = DEF_WFID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*WFID_W-1:0] src_wfid,
    output logic [NUM_SRC-1:0]        src_full,
    output logic [WFID_W-1:0]         tbl_rd_wfid,
    input  logic [INFO_W-1:0]         tbl_rd_data,
    output logic                      retire_valid,
    input  logic                      retire_ready,
    output logic [DONE_SRC_W-1:0]     retire_src,
    output logic [WFID_W-1:0]         retire_wfid,
    output logic [INFO_W-1:0]         retire_info,
    output logic [NUM_SRC-1:0]        overflow_err
);

    logic [WFID_W-1:0]     head [NUM_SRC];
    logic [NUM_SRC-1:0]    empty;
    logic [NUM_SRC-1:0]    pop;
    logic [DONE_SRC_W-1:0] ptr;
    logic [DONE_SRC_W-1:0] grant_idx;
    logic                  grant_any;
    logic                  grant_valid;
    logic                  out_free;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        done_fifo #(
            .WFID_W     (WFID_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (src_valid[g]),
            .pop   (pop[g]),
            .din   (src_wfid[g*WFID_W +: WFID_W]),
            .head  (head[g]),
            .full  (src_full[g]),
            .empty (empty[g])
        );
    end

    assign out_free = !retire_valid || retire_ready;

    // First non-empty FIFO scanning upward from the RR pointer, wrapping mod 4.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!grant_any && !empty[ptr + DONE_SRC_W'(k)]) begin
                grant_any = 1'b1;
                grant_idx = ptr + DONE_SRC_W'(k);
            end
        end
    end

    assign grant_valid = out_free && grant_any;
    assign pop         = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
    assign tbl_rd_wfid = grant_valid ? head[grant_idx] : head[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            retire_valid <= 1'b0;
            retire_src   <= '0;
            retire_wfid  <= '0;
            retire_info  <= '0;
            overflow_err <= '0;
        end else begin
            overflow_err <= overflow_err | (src_valid & src_full & ~pop);
            if (grant_valid) begin
                retire_valid <= 1'b1;
                retire_src   <= grant_idx;
                retire_wfid  <= head[grant_idx];
                retire_info  <= tbl_rd_data;
                ptr          <= grant_idx + 1'b1;
            end else if (retire_ready) begin
                retire_valid <= 1'b0;
            end
        end
    end

endmodule
